fp_align_add: RTL and testbench
===============================

// Module: fp_align_add
// PURPOSE
//   Upstream stage of the FP adder, feeding the normalize stage. Takes two IEEE-754
//   operands and unpacks them, aligns exponents and adds/subtracts the mantissas.
//   Left-normalizes after cancellation and emits {sign, exp, 25-bit mantissa}.
//   Normalize then only has to handle carry-out (bit 24).
//   Two-stage pipeline with valid/ready on both sides.
// PARAMETERS
//   EXP_W   8   exponent width; bias = 2^(EXP_W-1)-1
//   FRAC_W  23  stored fraction width; mantissa_out width = FRAC_W+2
// PORTS
//   clk            in   1               single clock, all flops posedge
//   rst_n          in   1               asynchronous, active-low reset
//   in_valid       in   1               operands a/b valid
//   in_ready       out  1               stage 1 can accept this cycle
//   a              in   1+EXP_W+FRAC_W  operand A {sign, exp, frac}
//   b              in   1+EXP_W+FRAC_W  operand B {sign, exp, frac}
//   out_valid      out  1               result valid to normalize
//   out_ready      in   1               normalize accepts result
//   mantissa_out   out  FRAC_W+2        bit FRAC_W+1 = carry, bit FRAC_W = hidden 1
//   exp_out        out  EXP_W           exponent before carry adjust
//   sign_out       out  1               result sign
// BEHAVIOUR
//   Reset: out_valid=0, mantissa_out=0, exp_out=0, sign_out=0, both stage valids 0.
//     Reset mid-operation discards in-flight data. No output pulse after release.
//   Handshake: a transfer happens when valid&&ready on the same edge.
//     Stage 2 advances when !out_valid || out_ready.
//     Stage 1 advances when !s1_valid || stage 2 advances; in_ready = that term, combinational.
//     Output regs hold stable while out_valid && !out_ready.
//     Latency is 2 cycles from input handshake to out_valid with no backpressure.
//     Sustained throughput is 1 per cycle. Simultaneous accept-in and drain-out is legal when full.
//   Stage 1 (align):
//     Unpack: exp==0 -> operand treated as zero (mantissa 0, denormals flushed).
//       Otherwise mantissa = {1, frac}.
//     Swap: the operand with the larger magnitude is L, the other is S.
//       Compare {exp, frac}. On a tie, L = a.
//     Alignment: d = L.exp - S.exp. S.mantissa >>= d.
//       If d >= FRAC_W+2, S.mantissa is 0. Shifted-out bits are truncated; there is no rounding.
//     eff_sub = a.sign ^ b.sign. Register L.mant, S.mant (aligned), L.exp, L.sign, eff_sub.
//   Stage 2 (add + left-normalize):
//     sum = eff_sub ? L - S : L + S, 25 bits, never negative because of the swap.
//     sum[24]=1 -> pass through, exp_out = L.exp (normalize increments).
//     sum==0 -> mantissa_out=0, exp_out=0, sign_out=0 (exact cancel gives +0).
//     Else (sum[24]=0) -> lz = leading zeros of sum[23:0]; shift left by lz so bit 23 = 1.
//       exp_out = L.exp - lz. If lz >= L.exp, flush the result to +0.
//     sign_out = L.sign, except +0 cases.
//     No exponent saturation here. Overflow to all-ones exp is normalize's concern.
// CONFIGURATION
//   FPADD_SPECIAL_EN defined: stage 1 detects exp == all-ones.
//     Any NaN input, or +inf + -inf -> sign 0, exp all-ones, mantissa_out = {2'b01,1,0...} (qNaN).
//     Single inf, or same-sign infs -> that sign, exp all-ones, mantissa_out = {2'b01, 0...}.
//     Special results bypass the add/normalize logic in stage 2 with the same latency.
//   FPADD_SPECIAL_EN undefined: exp all-ones is treated as an ordinary exponent.
//     No detection logic is built.
// TESTING
//   1. 1.0 + 1.0: a=3F800000, b=3F800000 -> after 2 cycles out_valid=1, mantissa_out=25'h1000000,
//      exp_out=7F, sign_out=0.
//   2. 1.5 + -1.0: a=3FC00000, b=BF800000 -> mantissa_out=25'h0800000, exp_out=7E, sign_out=0
//      (lz=1 path).
//   3. 1.0 + -1.0: a=3F800000, b=BF800000 -> mantissa_out=0, exp_out=0, sign_out=0.
//      Also run the operands swapped; the result is identical.
//   4. 2^24 + 1.0: a=4B800000, b=3F800000 -> mantissa_out=25'h0800000, exp_out=97 (S shifted to 0).
//   5. Backpressure: issue 3 back-to-back ops with out_ready=0 for 4 cycles.
//      in_ready drops after 2 accepts and the outputs stay frozen.
//      On release the 3 results come out in order on consecutive cycles with no loss or duplication.
//   6. Reset: drop rst_n with both stages valid -> out_valid=0 the same cycle, no stale output
//      after release. With FPADD_SPECIAL_EN: 7F800000 + FF800000 -> exp_out=FF, mantissa_out=25'h0C00000.

Source files
------------

// File: rtl/fp_align_add.sv
// fp_align_add: two-stage FP add front end (unpack/swap/align, then add and left-normalize).
// Optional inf/NaN handling is built when FPADD_SPECIAL_EN is defined.
module fp_align_add #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FRAC_W+1:0]     mantissa_out,
    output logic [EXP_W-1:0]      exp_out,
    output logic                  sign_out
);
    localparam int MANT_W = FRAC_W + 1;
    localparam int SUM_W  = FRAC_W + 2;
    localparam int LZ_W   = $clog2(SUM_W);

    logic              w_a_sign, w_b_sign;
    logic [EXP_W-1:0]  w_a_exp, w_b_exp;
    logic [FRAC_W-1:0] w_a_frac, w_b_frac;
    logic [MANT_W-1:0] w_a_mant, w_b_mant;
    logic              w_a_is_l;
    logic [MANT_W-1:0] w_l_mant, w_s_mant, w_s_mant_al;
    logic [EXP_W-1:0]  w_l_exp, w_s_exp, w_d;
    logic              w_l_sign;
    logic              w_s1_adv, w_s2_adv;

    logic              r_s1_valid;
    logic [MANT_W-1:0] r_l_mant, r_s_mant;
    logic [EXP_W-1:0]  r_l_exp;
    logic              r_l_sign, r_eff_sub;

    logic              r_out_valid;
    logic [SUM_W-1:0]  r_mant_out;
    logic [EXP_W-1:0]  r_exp_out;
    logic              r_sign_out;

    logic [SUM_W-1:0]  w_sum;
    logic [LZ_W-1:0]   w_lz;
    logic [SUM_W-1:0]  w_res_mant;
    logic [EXP_W-1:0]  w_res_exp;
    logic              w_res_sign;

    assign {w_a_sign, w_a_exp, w_a_frac} = a;
    assign {w_b_sign, w_b_exp, w_b_frac} = b;

    // Zero exponent flushes denormals to zero
    assign w_a_mant = (w_a_exp == '0) ? '0 : {1'b1, w_a_frac};
    assign w_b_mant = (w_b_exp == '0) ? '0 : {1'b1, w_b_frac};

    assign w_a_is_l    = ({w_a_exp, w_a_frac} >= {w_b_exp, w_b_frac});
    assign w_l_mant    = w_a_is_l ? w_a_mant : w_b_mant;
    assign w_s_mant    = w_a_is_l ? w_b_mant : w_a_mant;
    assign w_l_exp     = w_a_is_l ? w_a_exp  : w_b_exp;
    assign w_s_exp     = w_a_is_l ? w_b_exp  : w_a_exp;
    assign w_l_sign    = w_a_is_l ? w_a_sign : w_b_sign;
    assign w_d         = w_l_exp - w_s_exp;
    assign w_s_mant_al = (32'(w_d) >= 32'(SUM_W)) ? '0 : (w_s_mant >> w_d);

`ifdef FPADD_SPECIAL_EN
    logic w_a_max, w_b_max, w_a_nan, w_b_nan;
    logic w_spec, w_spec_nan, w_spec_sign;
    logic r_spec, r_spec_nan, r_spec_sign;

    assign w_a_max     = (w_a_exp == '1);
    assign w_b_max     = (w_b_exp == '1);
    assign w_a_nan     = w_a_max && (w_a_frac != '0);
    assign w_b_nan     = w_b_max && (w_b_frac != '0);
    assign w_spec      = w_a_max || w_b_max;
    assign w_spec_nan  = w_a_nan || w_b_nan || (w_a_max && w_b_max && (w_a_sign != w_b_sign));
    assign w_spec_sign = !w_spec_nan && (w_a_max ? w_a_sign : w_b_sign);
`endif

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_l_mant    <= '0;
            r_s_mant    <= '0;
            r_l_exp     <= '0;
            r_l_sign    <= 1'b0;
            r_eff_sub   <= 1'b0;
`ifdef FPADD_SPECIAL_EN
            r_spec      <= 1'b0;
            r_spec_nan  <= 1'b0;
            r_spec_sign <= 1'b0;
`endif
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_l_mant    <= w_l_mant;
                r_s_mant    <= w_s_mant_al;
                r_l_exp     <= w_l_exp;
                r_l_sign    <= w_l_sign;
                r_eff_sub   <= w_a_sign ^ w_b_sign;
`ifdef FPADD_SPECIAL_EN
                r_spec      <= w_spec;
                r_spec_nan  <= w_spec_nan;
                r_spec_sign <= w_spec_sign;
`endif
            end
        end
    end

    // Swap guarantees L >= S, so the difference never goes negative
    assign w_sum = r_eff_sub ? ({1'b0, r_l_mant} - {1'b0, r_s_mant})
                             : ({1'b0, r_l_mant} + {1'b0, r_s_mant});

    always_comb begin
        logic found;
        w_lz  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MANT_W; i++) begin
            if (!found && w_sum[MANT_W-1-i]) begin
                w_lz  = LZ_W'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        w_res_mant = w_sum;
        w_res_exp  = r_l_exp;
        w_res_sign = r_l_sign;
        if (w_sum[SUM_W-1]) begin
            w_res_mant = w_sum;
        end else if ((w_sum == '0) || (32'(w_lz) >= 32'(r_l_exp))) begin
            w_res_mant = '0;
            w_res_exp  = '0;
            w_res_sign = 1'b0;
        end else begin
            w_res_mant = w_sum << w_lz;
            w_res_exp  = r_l_exp - EXP_W'(w_lz);
        end
`ifdef FPADD_SPECIAL_EN
        if (r_spec) begin
            w_res_mant = {2'b01, r_spec_nan, {(FRAC_W-1){1'b0}}};
            w_res_exp  = '1;
            w_res_sign = r_spec_sign;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_mant_out  <= '0;
            r_exp_out   <= '0;
            r_sign_out  <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_mant_out <= w_res_mant;
                r_exp_out  <= w_res_exp;
                r_sign_out <= w_res_sign;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign mantissa_out = r_mant_out;
    assign exp_out      = r_exp_out;
    assign sign_out     = r_sign_out;

endmodule

// File: tb/tb_fp_align_add.sv
// Bench for fp_align_add: directed vector table, backpressure and reset sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_fp_align_add;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int NRAND  = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] mantissa_out;
    logic [7:0]  exp_out;
    logic        sign_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_align_add #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .mantissa_out(mantissa_out), .exp_out(exp_out), .sign_out(sign_out)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [33:0] res;
    } vec_t;

    vec_t vecs[$];
    logic [33:0] sb[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic add_vec(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [24:0] m, input logic [7:0] e, input logic s);
        vec_t v;
        v.name = name; v.a = x; v.b = y; v.res = {s, e, m};
        vecs.push_back(v);
    endtask

    function automatic logic [33:0] result();
        return {sign_out, exp_out, mantissa_out};
    endfunction

    // Reference: real-number view of the add with truncating alignment and flush rules
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] l, s;
        longint ml, ms, sum;
        int el, es, d, lz;
`ifdef FPADD_SPECIAL_EN
        bit xm, ym, nan;
        xm  = (x[30:23] == 8'hFF);
        ym  = (y[30:23] == 8'hFF);
        nan = (xm && x[22:0] != 0) || (ym && y[22:0] != 0) || (xm && ym && x[31] != y[31]);
        if (nan) return {1'b0, 8'hFF, 25'h0C00000};
        if (xm) return {x[31], 8'hFF, 25'h0800000};
        if (ym) return {y[31], 8'hFF, 25'h0800000};
`endif
        if (x[30:0] >= y[30:0]) begin l = x; s = y; end
        else begin l = y; s = x; end
        el = int'(l[30:23]);
        es = int'(s[30:23]);
        ml = (el == 0) ? 0 : longint'({1'b1, l[22:0]});
        ms = (es == 0) ? 0 : longint'({1'b1, s[22:0]});
        d  = el - es;
        ms = (d >= 25) ? 0 : (ms >> d);
        sum = (x[31] != y[31]) ? (ml - ms) : (ml + ms);
        if (sum == 0) return '0;
        if (sum >= 64'h1000000) return {l[31], l[30:23], 25'(sum)};
        lz = 0;
        while (sum < 64'h800000) begin
            sum = sum * 2;
            lz++;
        end
        if (lz >= el) return '0;
        return {l[31], 8'(el - lz), 25'(sum)};
    endfunction

    task automatic gen_pair(output logic [31:0] x, output logic [31:0] y);
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 4))
            0: ;
            1: y = {1'($urandom), x[30:23] + 8'($urandom_range(0, 2)), x[22:0] ^ 23'($urandom_range(0, 255))};
            2: begin
                x[30:23] = 8'($urandom_range(0, 3));
                y[30:23] = 8'($urandom_range(0, 3));
            end
            3: y = {~x[31], x[30:0] ^ 31'($urandom_range(0, 3))};
            default: begin
                if ($urandom_range(0, 1) == 1) x[30:23] = 8'hFF;
                else y[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 1) x[22:0] = '0;
                if ($urandom_range(0, 1) == 1) y[22:0] = '0;
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        logic [31:0] ra, rb;
        int lat, stale;
        int sent;
        bit timed_out;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;

        add_vec("one_plus_one",   32'h3F800000, 32'h3F800000, 25'h1000000, 8'h7F, 1'b0);
        add_vec("lz1_sub",        32'h3FC00000, 32'hBF800000, 25'h0800000, 8'h7E, 1'b0);
        add_vec("cancel",         32'h3F800000, 32'hBF800000, 25'h0000000, 8'h00, 1'b0);
        add_vec("cancel_swapped", 32'hBF800000, 32'h3F800000, 25'h0000000, 8'h00, 1'b0);
        add_vec("d24_add",        32'h4B800000, 32'h3F800000, 25'h0800000, 8'h97, 1'b0);
        add_vec("d24_sub",        32'h4B800000, 32'hBF800000, 25'h0800000, 8'h97, 1'b0);
        add_vec("d25",            32'h4C000000, 32'h3F800000, 25'h0800000, 8'h98, 1'b0);
        add_vec("d23_trunc",      32'h4B000000, 32'h3F800000, 25'h0800001, 8'h96, 1'b0);
        add_vec("two_plus_one",   32'h40000000, 32'h3F800000, 25'h0C00000, 8'h80, 1'b0);
        add_vec("neg_neg",        32'hBF800000, 32'hBF800000, 25'h1000000, 8'h7F, 1'b1);
        add_vec("b_larger_neg",   32'h3F800000, 32'hBFC00000, 25'h0800000, 8'h7E, 1'b1);
        add_vec("zero_plus_one",  32'h00000000, 32'h3F800000, 25'h0800000, 8'h7F, 1'b0);
        add_vec("denorm_flush",   32'h00000001, 32'h00000000, 25'h0000000, 8'h00, 1'b0);
        add_vec("lz_ge_exp",      32'h00C00000, 32'h80800000, 25'h0000000, 8'h00, 1'b0);
        add_vec("lz_lt_exp",      32'h01400000, 32'h81000000, 25'h0800000, 8'h01, 1'b0);
        add_vec("negzero_sum",    32'h80000000, 32'h80000000, 25'h0000000, 8'h00, 1'b0);
`ifdef FPADD_SPECIAL_EN
        add_vec("inf_minus_inf",  32'h7F800000, 32'hFF800000, 25'h0C00000, 8'hFF, 1'b0);
        add_vec("inf_plus_one",   32'h7F800000, 32'h3F800000, 25'h0800000, 8'hFF, 1'b0);
        add_vec("ninf_ninf",      32'hFF800000, 32'hFF800000, 25'h0800000, 8'hFF, 1'b1);
        add_vec("one_plus_ninf",  32'h3F800000, 32'hFF800000, 25'h0800000, 8'hFF, 1'b1);
        add_vec("nan_in",         32'h3F800000, 32'hFFC00001, 25'h0C00000, 8'hFF, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_release_idle", 64'(out_valid), 64'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b;
            #1 check({vecs[i].name, "_in_ready"}, 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd2);
            check(vecs[i].name, 64'(result()), 64'(vecs[i].res));
        end

        pa[0] = 32'h3F800000; pb[0] = 32'h3F800000;
        pa[1] = 32'h3FC00000; pb[1] = 32'hBF800000;
        pa[2] = 32'h40000000; pb[2] = 32'h3F800000;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = pa[0]; b = pb[0];
        #1 check("bp_accept0", 64'(in_ready), 64'd1);
        @(negedge clk);
        a = pa[1]; b = pb[1];
        #1 check("bp_accept1", 64'(in_ready), 64'd1);
        @(negedge clk);
        a = pa[2]; b = pb[2];
        #1 check("bp_ready_drop", 64'(in_ready), 64'd0);
        check("bp_head", 64'({out_valid, result()}), 64'({1'b1, model(pa[0], pb[0])}));
        repeat (2) begin
            @(negedge clk);
            #1 check("bp_stall_ready", 64'(in_ready), 64'd0);
            check("bp_frozen", 64'({out_valid, result()}), 64'({1'b1, model(pa[0], pb[0])}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_out0", 64'({out_valid, result()}), 64'({1'b1, model(pa[0], pb[0])}));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out1", 64'({out_valid, result()}), 64'({1'b1, model(pa[1], pb[1])}));
        @(negedge clk);
        check("bp_out2", 64'({out_valid, result()}), 64'({1'b1, model(pa[2], pb[2])}));
        @(negedge clk);
        check("bp_no_dup", 64'(out_valid), 64'd0);

        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = pa[0]; b = pb[0];
        @(negedge clk);
        a = pa[1]; b = pb[1];
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("rst_full_valid", 64'(out_valid), 64'd1);
        check("rst_full_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1 check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_result", 64'(result()), 64'd0);
        check("rst_s1_cleared", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_no_stale", 64'(stale), 64'd0);

        sent = 0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < NRAND && $urandom_range(0, 4) != 0) begin
                gen_pair(ra, rb);
                in_valid = 1'b1; a = ra; b = rb;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("rand_spurious", 64'(out_valid), 64'd0);
                else check("rand_result", 64'(result()), 64'(sb.pop_front()));
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b));
                sent++;
            end
            if (sent == NRAND && sb.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
        check("rand_drain", 64'(timed_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
